// File: rtl/wave_pkg.sv
// Shared definitions for the waveform capture path: FSM encodings and RAM geometry.
package wave_pkg;

  localparam int unsigned SAMPLES_PER_CAPTURE = 256;
  localparam int unsigned WAVE_RAM_ADDR_BITS  = 9;

  typedef enum logic [1:0] {
    StArmed  = 2'd0,
    StActive = 2'd1,
    StWait   = 2'd2
  } state_e;

endpackage

// File: rtl/dffre.sv
// Register cell with synchronous active-high clear and load enable.
module dffre #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Writer side of the double-buffered wave RAM: arms on a rising zero crossing, fills the
// half the display is not reading, then flips halves during display idle.
module wave_capture
  import wave_pkg::*;
#(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned HALF_BITS    = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    new_sample_ready,
  input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
  input  logic                    wave_display_idle,
  output logic [HALF_BITS:0]      write_address,
  output logic                    write_enable,
  output logic [7:0]              write_sample,
  output logic                    read_index
);

  localparam logic [HALF_BITS-1:0] CountLast = HALF_BITS'(SAMPLES_PER_CAPTURE - 1);
  localparam logic [HALF_BITS-1:0] CountOne  = HALF_BITS'(1);

  logic [1:0]              r_state;
  logic [HALF_BITS-1:0]    r_count;
  logic [SAMPLE_WIDTH-1:0] r_prev_sample;
  logic                    r_read_index;

  state_e                  w_state;
  state_e                  w_state_next;
  logic                    w_zero_cross;
  logic                    w_write;
  logic                    w_flip;
  logic [HALF_BITS-1:0]    w_count_next;
  logic [HALF_BITS:0]      w_address;
  logic [7:0]              w_sample_conv;

  assign w_state = state_e'(r_state);

  assign w_zero_cross = new_sample_ready & r_prev_sample[SAMPLE_WIDTH-1] &
                        ~new_sample_in[SAMPLE_WIDTH-1];

  // Count is 0 while armed, so the crossing sample lands at offset 0 and count becomes 1.
  assign w_count_next  = r_count + CountOne;
  assign w_address     = {~r_read_index, r_count};
  assign w_sample_conv = {~new_sample_in[SAMPLE_WIDTH-1], new_sample_in[SAMPLE_WIDTH-2 -: 7]};

  always_comb begin
    w_state_next = w_state;
    unique case (w_state)
      StArmed:  if (w_zero_cross) w_state_next = StActive;
      StActive: if (new_sample_ready && (r_count == CountLast)) w_state_next = StWait;
      StWait:   if (wave_display_idle) w_state_next = StArmed;
      default:  w_state_next = StArmed;
    endcase
  end

  always_comb begin
    w_write = 1'b0;
    w_flip  = 1'b0;
    unique case (w_state)
      StArmed:  w_write = w_zero_cross;
      StActive: w_write = new_sample_ready;
      StWait:   w_flip  = wave_display_idle;
      default:  ;
    endcase
  end

  dffre #(.WIDTH(2)) u_state (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (1'b1),
    .i_d     (w_state_next),
    .o_q     (r_state)
  );

  dffre #(.WIDTH(HALF_BITS)) u_count (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_write),
    .i_d     (w_count_next),
    .o_q     (r_count)
  );

  dffre #(.WIDTH(SAMPLE_WIDTH)) u_prev_sample (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (new_sample_ready),
    .i_d     (new_sample_in),
    .o_q     (r_prev_sample)
  );

  dffre #(.WIDTH(1)) u_read_index (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_flip),
    .i_d     (~r_read_index),
    .o_q     (r_read_index)
  );

  dffre #(.WIDTH(1)) u_write_enable (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (1'b1),
    .i_d     (w_write),
    .o_q     (write_enable)
  );

  // Address and data hold between writes.
  dffre #(.WIDTH(HALF_BITS + 1)) u_write_address (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_write),
    .i_d     (w_address),
    .o_q     (write_address)
  );

  dffre #(.WIDTH(8)) u_write_sample (
    .i_clk   (clk),
    .i_reset (reset),
    .i_en    (w_write),
    .i_d     (w_sample_conv),
    .o_q     (write_sample)
  );

  assign read_index = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// Bench for wave_capture: scoreboard of expected RAM writes plus per-scenario state checks.
module tb_wave_capture;
  import wave_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  int n_pass = 0;
  int n_total = 0;
  int n_writes = 0;
  int run = 0;
  int max_run = 0;
  int w0;
  logic [16:0] exp_q[$];
  logic [16:0] mon_e;

  always #5 clk = ~clk;

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      n_writes++;
      run++;
      if (run > max_run) max_run = run;
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, want no write",
                 write_address, write_sample);
      end else begin
        mon_e = exp_q.pop_front();
        if ({write_address, write_sample} !== mon_e)
          $display("FAIL write: got addr=%h data=%h, want addr=%h data=%h",
                   write_address, write_sample, mon_e[16:8], mon_e[7:0]);
        else n_pass++;
      end
    end else begin
      run = 0;
    end
  end

  function automatic logic [7:0] conv(input logic [15:0] s);
    return {~s[15], s[14:8]};
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] s);
    new_sample_in = s;
    new_sample_ready = 1'b1;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycles(2);
    n_total++; if (write_enable !== 1'b0) $display("FAIL rst_we: got %b, want 0", write_enable); else n_pass++;
    n_total++; if (write_address !== 9'h000) $display("FAIL rst_addr: got %h, want 000", write_address); else n_pass++;
    n_total++; if (write_sample !== 8'h00) $display("FAIL rst_data: got %h, want 00", write_sample); else n_pass++;
    n_total++; if (read_index !== 1'b0) $display("FAIL rst_ri: got %b, want 0", read_index); else n_pass++;
    n_total++; if (dut.w_state !== StArmed) $display("FAIL rst_state: got %0d, want %0d", dut.w_state, StArmed); else n_pass++;
    n_total++; if (dut.r_count !== 8'd0) $display("FAIL rst_count: got %0d, want 0", dut.r_count); else n_pass++;
    reset = 1'b0;
    w0 = n_writes;
    strobe(16'h1000);
    strobe(16'hF000);
    cycles(2);
    n_total++; if (n_writes !== w0) $display("FAIL rst_nowrite: got %0d writes, want 0", n_writes - w0); else n_pass++;
    n_total++; if (dut.w_state !== StArmed) $display("FAIL rst_armed: got %0d, want %0d", dut.w_state, StArmed); else n_pass++;
  endtask

  task automatic test_capture;
    logic [15:0] s;
    w0 = n_writes;
    strobe(16'hFF9C);
    exp_q.push_back({9'h100, 8'h80});
    strobe(16'd50);
    for (int i = 1; i < 256; i++) begin
      s = 16'(i << 8);
      exp_q.push_back({9'h100 + 9'(i), conv(s)});
      strobe(s);
    end
    cycles(2);
    n_total++; if (n_writes - w0 !== 256) $display("FAIL cap_count: got %0d, want 256", n_writes - w0); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL cap_pending: got %0d, want 0", exp_q.size()); else n_pass++;
    n_total++; if (dut.w_state !== StWait) $display("FAIL cap_state: got %0d, want %0d", dut.w_state, StWait); else n_pass++;
    w0 = n_writes;
    strobe(16'h8000);
    strobe(16'h0100);
    strobe(16'hC000);
    cycles(2);
    n_total++; if (n_writes !== w0) $display("FAIL wait_nowrite: got %0d, want 0", n_writes - w0); else n_pass++;
    n_total++; if (read_index !== 1'b0) $display("FAIL wait_ri: got %b, want 0", read_index); else n_pass++;
    n_total++; if (dut.w_state !== StWait) $display("FAIL wait_state: got %0d, want %0d", dut.w_state, StWait); else n_pass++;
  endtask

  // Idle cycle also carries a rising crossing that must not be captured.
  task automatic test_swap(input logic exp_ri);
    w0 = n_writes;
    n_total++; if (read_index !== ~exp_ri) $display("FAIL swap_pre: got %b, want %b", read_index, ~exp_ri); else n_pass++;
    wave_display_idle = 1'b1;
    new_sample_in = 16'h0200;
    new_sample_ready = 1'b1;
    @(posedge clk);
    #1;
    wave_display_idle = 1'b0;
    new_sample_ready = 1'b0;
    n_total++; if (read_index !== exp_ri) $display("FAIL swap_ri: got %b, want %b", read_index, exp_ri); else n_pass++;
    n_total++; if (dut.w_state !== StArmed) $display("FAIL swap_state: got %0d, want %0d", dut.w_state, StArmed); else n_pass++;
    cycles(2);
    n_total++; if (n_writes !== w0) $display("FAIL swap_nowrite: got %0d, want 0", n_writes - w0); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [15:0] s;
    strobe(16'hFFFF);
    exp_q.push_back({9'h000, 8'h80});
    strobe(16'h0000);
    for (int i = 1; i < 100; i++) begin
      s = 16'(i * 100);
      exp_q.push_back({9'(i), conv(s)});
      strobe(s);
    end
    cycles(1);
    reset = 1'b1;
    cycles(2);
    n_total++; if (read_index !== 1'b0) $display("FAIL mid_ri: got %b, want 0", read_index); else n_pass++;
    n_total++; if (dut.r_count !== 8'd0) $display("FAIL mid_count: got %0d, want 0", dut.r_count); else n_pass++;
    n_total++; if (dut.w_state !== StArmed) $display("FAIL mid_state: got %0d, want %0d", dut.w_state, StArmed); else n_pass++;
    n_total++; if (write_address !== 9'h000) $display("FAIL mid_addr: got %h, want 000", write_address); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL mid_pending: got %0d, want 0", exp_q.size()); else n_pass++;
    reset = 1'b0;
  endtask

  // Restarts at 0x100 after the mid-capture reset, with the strobe held high throughout.
  task automatic test_throughput;
    logic [15:0] s;
    logic [7:0]  d;
    strobe(16'hFF00);
    max_run = 0;
    w0 = n_writes;
    new_sample_ready = 1'b1;
    for (int i = 0; i < 257; i++) begin
      case (i)
        0:       begin s = 16'h0000; d = 8'h80; end
        1:       begin s = 16'h8000; d = 8'h00; end
        2:       begin s = 16'h7FFF; d = 8'hFF; end
        256:     begin s = 16'hF000; d = 8'h00; end
        default: begin s = 16'(i * 257); d = conv(s); end
      endcase
      if (i < 256) exp_q.push_back({9'h100 + 9'(i), d});
      new_sample_in = s;
      @(posedge clk);
      #1;
    end
    new_sample_ready = 1'b0;
    cycles(2);
    n_total++; if (max_run !== 256) $display("FAIL thr_run: got %0d, want 256", max_run); else n_pass++;
    n_total++; if (n_writes - w0 !== 256) $display("FAIL thr_count: got %0d, want 256", n_writes - w0); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL thr_pending: got %0d, want 0", exp_q.size()); else n_pass++;
    n_total++; if (dut.w_state !== StWait) $display("FAIL thr_state: got %0d, want %0d", dut.w_state, StWait); else n_pass++;
  endtask

  task automatic test_ignored;
    logic [15:0] s;
    w0 = n_writes;
    wave_display_idle = 1'b1;
    cycles(1);
    wave_display_idle = 1'b0;
    n_total++; if (read_index !== 1'b1) $display("FAIL ign_armed_ri: got %b, want 1", read_index); else n_pass++;
    n_total++; if (dut.w_state !== StArmed) $display("FAIL ign_armed_state: got %0d, want %0d", dut.w_state, StArmed); else n_pass++;
    strobe(16'h9000);
    exp_q.push_back({9'h000, conv(16'h1000)});
    strobe(16'h1000);
    for (int i = 1; i < 256; i++) begin
      if (i == 50) begin
        wave_display_idle = 1'b1;
        cycles(1);
        wave_display_idle = 1'b0;
        n_total++; if (dut.r_count !== 8'd50) $display("FAIL ign_active_count: got %0d, want 50", dut.r_count); else n_pass++;
        n_total++; if (read_index !== 1'b1) $display("FAIL ign_active_ri: got %b, want 1", read_index); else n_pass++;
      end
      s = (i == 100) ? 16'hA000 : (i == 101) ? 16'h2000 : 16'(i * 64);
      exp_q.push_back({9'(i), conv(s)});
      strobe(s);
      if (i == 102) begin
        n_total++; if (dut.r_count !== 8'd103) $display("FAIL ign_cross_count: got %0d, want 103", dut.r_count); else n_pass++;
      end
    end
    cycles(2);
    n_total++; if (n_writes - w0 !== 256) $display("FAIL ign_count: got %0d, want 256", n_writes - w0); else n_pass++;
    n_total++; if (exp_q.size() !== 0) $display("FAIL ign_pending: got %0d, want 0", exp_q.size()); else n_pass++;
    n_total++; if (read_index !== 1'b1) $display("FAIL ign_ri: got %b, want 1", read_index); else n_pass++;
    n_total++; if (dut.w_state !== StWait) $display("FAIL ign_state: got %0d, want %0d", dut.w_state, StWait); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_capture();
    test_swap(1'b1);
    test_reset_mid();
    test_throughput();
    test_swap(1'b1);
    test_ignored();
    cycles(2);
    n_total++; if (exp_q.size() !== 0) $display("FAIL final_pending: got %0d, want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
